// File: rtl/bit_ram_pkg.sv
// Shared definitions for the bit-RAM controller: op codes, FSM states and
// default bit-RAM geometry.
package bit_ram_pkg;

  localparam int ADDR_LEN_DEF = 8;
  localparam int DEPTH_DEF    = 256;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_LDN = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_STN = 3'd3;
  localparam logic [2:0] OP_S   = 3'd4;
  localparam logic [2:0] OP_R   = 3'd5;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    ISSUE   = 2'd2,
    RD_WAIT = 2'd3
  } ctrlState_e;

  function automatic logic isReadOp(input logic [2:0] opCode);
    return (opCode == OP_LD) || (opCode == OP_LDN);
  endfunction

endpackage

// File: rtl/bit_ram_init_sweep.sv
// Address counter for the post-reset clear sweep of the bit-RAM, with
// terminal detect on the last real location rather than on counter wrap.
module bit_ram_init_sweep
  import bit_ram_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sweepEn,
  output logic [ADDR_LEN-1:0] sweepAddr,
  output logic                sweepDone
);

  logic [ADDR_LEN-1:0] count_r;

  assign sweepAddr = count_r;
  assign sweepDone = (count_r == ADDR_LEN'(DEPTH - 1));

  // Sweep counter; parks on the last address so only reset restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {ADDR_LEN{1'b0}};
    end else if (sweepEn && !sweepDone) begin
      count_r <= count_r + ADDR_LEN'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/bit_ram_ctrl.sv
// Bit-RAM controller: clears the RAM after reset, then turns LD/LDN/ST/STN/S/R
// requests into timed bit-RAM strobes and returns read data or completion.
module bit_ram_ctrl
  import bit_ram_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [2:0]          op,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                accIn,
  input  logic                bitRamOut,
  output logic                ready,
  output logic                rdData,
  output logic                rdValid,
  output logic                wrDone,
  output logic                opErr,
  output logic                initDone,
  output logic                bitRamEn,
  output logic                bitRamRw,
  output logic [ADDR_LEN-1:0] bitRamAddr,
  output logic                bitRamIn
);

  ctrlState_e          state_r;
  ctrlState_e          nextState_s;
  logic [2:0]          opLat_r;
  logic [2:0]          opLatNext_s;
  logic                sweepEn_s;
  logic [ADDR_LEN-1:0] sweepAddr_s;
  logic                sweepDone_s;

  logic                enNext_s;
  logic                rwNext_s;
  logic [ADDR_LEN-1:0] addrNext_s;
  logic                inNext_s;
  logic                rdDataNext_s;
  logic                rdValidNext_s;
  logic                wrDoneNext_s;
  logic                opErrNext_s;
  logic                initDoneNext_s;

  bit_ram_init_sweep #(
    .ADDR_LEN(ADDR_LEN),
    .DEPTH   (DEPTH)
  ) u_sweep (
    .clk      (clk),
    .reset    (reset),
    .sweepEn  (sweepEn_s),
    .sweepAddr(sweepAddr_s),
    .sweepDone(sweepDone_s)
  );

  assign ready = (state_r == IDLE) & ~reset;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    nextState_s    = state_r;
    opLatNext_s    = opLat_r;
    sweepEn_s      = 1'b0;
    enNext_s       = 1'b0;
    rwNext_s       = bitRamRw;
    addrNext_s     = bitRamAddr;
    inNext_s       = bitRamIn;
    rdDataNext_s   = rdData;
    rdValidNext_s  = 1'b0;
    wrDoneNext_s   = 1'b0;
    opErrNext_s    = 1'b0;
    initDoneNext_s = initDone;
    case (state_r)
      INIT: begin
        sweepEn_s  = 1'b1;
        enNext_s   = 1'b1;
        rwNext_s   = 1'b0;
        inNext_s   = 1'b0;
        addrNext_s = sweepAddr_s;
        if (sweepDone_s) begin
          nextState_s    = IDLE;
          initDoneNext_s = 1'b1;
        end else begin
          nextState_s = INIT;
        end
      end
      IDLE: begin
        if (req) begin
          opLatNext_s = op;
          nextState_s = ISSUE;
          // S/R with a clear condition still complete, just without a RAM write
          case (op)
            OP_LD, OP_LDN: begin
              enNext_s   = 1'b1;
              rwNext_s   = 1'b1;
              addrNext_s = addr;
            end
            OP_ST: begin
              enNext_s   = 1'b1;
              rwNext_s   = 1'b0;
              inNext_s   = accIn;
              addrNext_s = addr;
            end
            OP_STN: begin
              enNext_s   = 1'b1;
              rwNext_s   = 1'b0;
              inNext_s   = ~accIn;
              addrNext_s = addr;
            end
            OP_S: begin
              enNext_s   = accIn;
              rwNext_s   = 1'b0;
              inNext_s   = 1'b1;
              addrNext_s = addr;
            end
            OP_R: begin
              enNext_s   = accIn;
              rwNext_s   = 1'b0;
              inNext_s   = 1'b0;
              addrNext_s = addr;
            end
            default: begin
              opErrNext_s = 1'b1;
              nextState_s = IDLE;
            end
          endcase
        end else begin
          nextState_s = IDLE;
        end
      end
      ISSUE: begin
        if (isReadOp(opLat_r)) begin
          // Keep the read strobe up so bitRamOut stays driven through capture
          enNext_s    = 1'b1;
          rwNext_s    = 1'b1;
          nextState_s = RD_WAIT;
        end else begin
          wrDoneNext_s = 1'b1;
          nextState_s  = IDLE;
        end
      end
      RD_WAIT: begin
        rdDataNext_s  = bitRamOut ^ (opLat_r == OP_LDN);
        rdValidNext_s = 1'b1;
        nextState_s   = IDLE;
      end
      default: begin
        nextState_s = INIT;
      end
    endcase
  end

  // Op latch and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      opLat_r    <= OP_LD;
      bitRamEn   <= 1'b0;
      bitRamRw   <= 1'b0;
      bitRamAddr <= {ADDR_LEN{1'b0}};
      bitRamIn   <= 1'b0;
      rdData     <= 1'b0;
      rdValid    <= 1'b0;
      wrDone     <= 1'b0;
      opErr      <= 1'b0;
      initDone   <= 1'b0;
    end else begin
      opLat_r    <= opLatNext_s;
      bitRamEn   <= enNext_s;
      bitRamRw   <= rwNext_s;
      bitRamAddr <= addrNext_s;
      bitRamIn   <= inNext_s;
      rdData     <= rdDataNext_s;
      rdValid    <= rdValidNext_s;
      wrDone     <= wrDoneNext_s;
      opErr      <= opErrNext_s;
      initDone   <= initDoneNext_s;
    end
  end

endmodule

// File: tb/tb_bit_ram_ctrl.sv
// Self-checking bench for bit_ram_ctrl: a cycle-indexed expectation model
// driven by per-op latency rules, plus literal checks on key results.
module tb_bit_ram_ctrl;
  import bit_ram_pkg::*;

  localparam int AL   = 4;
  localparam int DP   = 16;
  localparam int MAXC = 1024;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic          clk = 1'b0;
  logic          reset, req, accIn, bitRamOut;
  logic [2:0]    op;
  logic [AL-1:0] addr;
  logic          ready, rdData, rdValid, wrDone, opErr, initDone;
  logic          bitRamEn, bitRamRw, bitRamIn;
  logic [AL-1:0] bitRamAddr;

  bit_ram_ctrl #(.ADDR_LEN(AL), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .accIn(accIn),
    .bitRamOut(bitRamOut), .ready(ready), .rdData(rdData), .rdValid(rdValid),
    .wrDone(wrDone), .opErr(opErr), .initDone(initDone), .bitRamEn(bitRamEn),
    .bitRamRw(bitRamRw), .bitRamAddr(bitRamAddr), .bitRamIn(bitRamIn)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Behavioural bit-RAM: no array reset (powers up all ones), registered read
  logic [DP-1:0] ram = {DP{1'b1}};
  logic          ramQ = 1'b0;
  always @(posedge clk) begin
    if (reset) ramQ <= 1'b0;
    else if (bitRamEn) begin
      if (bitRamRw) ramQ <= ram[bitRamAddr];
      else ram[bitRamAddr] <= bitRamIn;
    end
  end
  assign bitRamOut = ramQ & bitRamEn & bitRamRw;

  // Expectations indexed by cycle (cycle n lies between edge n-1 and edge n)
  bit expBusy[MAXC];
  bit expInit[MAXC];
  bit expEn[MAXC];
  bit expRw[MAXC];
  int expAddr[MAXC];
  bit expIn[MAXC];
  bit expRdV[MAXC];
  bit expRdD[MAXC];
  bit expWr[MAXC];
  bit expErr[MAXC];
  bit refMem[DP];
  int nextFree  = MAXC;
  int checkFrom = MAXC;
  int lastReset = 0;
  int nChecks   = 0;
  int nErrors   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, edges + 1, got, exp);
    end
  endtask

  task automatic doReset();
    int r;
    r = edges + 1;
    reset = 1'b1;
    req   = 1'b0;
    if (checkFrom == MAXC) checkFrom = r + 1;
    expBusy[r] = 1'b1;
    for (int c = r + 1; c < MAXC; c++) begin
      expBusy[c] = (c <= r + DP);
      expInit[c] = (c >= r + DP + 1);
      expEn[c]   = (c >= r + 2) && (c <= r + DP + 1);
      expRw[c]   = 1'b0;
      expAddr[c] = c - r - 2;
      expIn[c]   = 1'b0;
      expRdV[c]  = 1'b0;
      expRdD[c]  = 1'b0;
      expWr[c]   = 1'b0;
      expErr[c]  = 1'b0;
    end
    for (int i = 0; i < DP; i++) refMem[i] = 1'b0;
    nextFree  = r + DP + 1;
    lastReset = r;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Record what a transfer at edge t must produce
  task automatic model(input logic [2:0] o, input int a, input logic acc, input int t);
    bit doWrite;
    bit val;
    doWrite = 1'b0;
    val     = 1'b0;
    if (o == OP_LD || o == OP_LDN) begin
      for (int c = t + 1; c < t + RD_LAT; c++) begin
        expEn[c] = 1'b1; expRw[c] = 1'b1; expAddr[c] = a; expBusy[c] = 1'b1;
      end
      expRdV[t + RD_LAT] = 1'b1;
      expRdD[t + RD_LAT] = refMem[a] ^ (o == OP_LDN);
      nextFree = t + RD_LAT;
    end else if (o <= OP_R) begin
      if (o == OP_ST)  begin doWrite = 1'b1; val = acc;  end
      if (o == OP_STN) begin doWrite = 1'b1; val = !acc; end
      if (o == OP_S)   begin doWrite = acc;  val = 1'b1; end
      if (o == OP_R)   begin doWrite = acc;  val = 1'b0; end
      if (doWrite) begin
        expEn[t + 1] = 1'b1; expRw[t + 1] = 1'b0; expAddr[t + 1] = a; expIn[t + 1] = val;
        refMem[a] = val;
      end
      expBusy[t + 1] = 1'b1;
      expWr[t + WR_LAT] = 1'b1;
      nextFree = t + WR_LAT;
    end else begin
      expErr[t + 1] = 1'b1;
      nextFree = t + 1;
    end
  endtask

  // Holds req from the call until the model says the controller is ready
  task automatic issue(input logic [2:0] o, input int a, input logic acc);
    req = 1'b1; op = o; addr = AL'(a); accIn = acc;
    while (edges + 1 < nextFree) begin
      @(posedge clk); #1;
    end
    model(o, a, acc, edges + 1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic waitRd(input logic want, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdValid && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (!rdValid) chk({nm, "_timeout"}, 0, 1);
    else chk(nm, rdData, want);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int c;
    c = edges + 1;
    if (c >= checkFrom && c < MAXC) begin
      chk("ready", ready, !expBusy[c]);
      chk("initDone", initDone, expInit[c]);
      chk("bitRamEn", bitRamEn, expEn[c]);
      if (expEn[c]) begin
        chk("bitRamRw", bitRamRw, expRw[c]);
        chk("bitRamAddr", bitRamAddr, expAddr[c]);
        if (!expRw[c]) chk("bitRamIn", bitRamIn, expIn[c]);
      end
      chk("rdValid", rdValid, expRdV[c]);
      if (expRdV[c]) chk("rdData", rdData, expRdD[c]);
      chk("wrDone", wrDone, expWr[c]);
      chk("opErr", opErr, expErr[c]);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", nErrors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; op = OP_LD; addr = '0; accIn = 1'b0;
    doReset();

    issue(OP_ST, 5, 1'b1);
    issue(OP_LD, 5, 1'b0);   waitRd(1'b1, "lit_ld5");
    issue(OP_LDN, 5, 1'b0);  waitRd(1'b0, "lit_ldn5");
    issue(OP_S, 7, 1'b0);
    issue(OP_LD, 7, 1'b0);   waitRd(1'b0, "lit_s0_no_write");
    issue(OP_S, 7, 1'b1);
    issue(OP_LD, 7, 1'b0);   waitRd(1'b1, "lit_s1_sets");
    issue(OP_R, 7, 1'b1);
    issue(OP_LD, 7, 1'b0);   waitRd(1'b0, "lit_r1_clears");
    issue(OP_STN, 2, 1'b0);
    issue(OP_LDN, 2, 1'b0);  waitRd(1'b0, "lit_stn_ldn2");
    issue(OP_LD, 12, 1'b0);  waitRd(1'b0, "lit_swept_zero");

    issue(3'd6, 0, 1'b0);
    @(negedge clk);
    chk("lit_opErr", opErr, 1);
    chk("lit_ready_after_err", ready, 1);
    issue(3'd7, 1, 1'b1);

    // Back-to-back reads with req held through the busy cycles
    issue(OP_ST, 3, 1'b1);
    for (int k = 0; k < 3; k++) issue(OP_LD, 3, 1'b0);
    waitRd(1'b1, "lit_ld3_stream");

    // Reset lands in the ISSUE cycle of a write
    issue(OP_ST, 9, 1'b1);
    doReset();
    @(negedge clk);
    while (edges + 1 < lastReset + DP) @(negedge clk);
    chk("lit_ready_in_sweep", ready, 0);
    chk("lit_initDone_in_sweep", initDone, 0);
    @(negedge clk);
    chk("lit_ready_after_sweep", ready, 1);
    chk("lit_initDone_after_sweep", initDone, 1);
    chk("lit_last_sweep_addr", bitRamAddr, DP - 1);
    issue(OP_LD, 9, 1'b0);   waitRd(1'b0, "lit_ld9_after_reset");
    issue(OP_LD, 5, 1'b0);   waitRd(1'b0, "lit_ld5_after_reset");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/bit_ram_ctrl.md
Name: bit_ram_ctrl

Overview:
Upstream controller for the bit-RAM. It takes bit-memory operations from the execute stage: LD, LDN, ST, STN, S and R. It turns each into correctly timed bitRamEn/bitRamRw/bitRamAddr/bitRamIn strobes, captures bitRamOut at the right cycle, and returns data or completion to the pipeline. After reset it sweeps the whole bit-RAM to 0, because the RAM array itself has no reset.

Parameters:
ADDR_LEN, 8, bit-RAM address width; equals bitRamAddrLen.
DEPTH, 256, number of bit locations; equals bitRamDepth; must satisfy DEPTH <= 2^ADDR_LEN.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset. Shared with bitRam.
req  in  1  operation request from execute stage.
op  in  3  operation code: 0 LD, 1 LDN, 2 ST, 3 STN, 4 S, 5 R, 6-7 illegal.
addr  in  ADDR_LEN  target bit address.
accIn  in  1  accumulator bit; write data for ST/STN, condition for S/R.
ready  out  1  controller can accept a request this cycle.
rdData  out  1  read result; valid only while rdValid=1.
rdValid  out  1  one-cycle pulse, read result available.
wrDone  out  1  one-cycle pulse, write-class op (ST/STN/S/R) complete.
opErr  out  1  one-cycle pulse, illegal op was accepted and dropped.
initDone  out  1  high once the clear sweep has finished.
bitRamEn  out  1  to bitRam enable.
bitRamRw  out  1  to bitRam: 1 = read, 0 = write.
bitRamAddr  out  ADDR_LEN  to bitRam address.
bitRamIn  out  1  to bitRam write data.

Behaviour:
- All outputs are registered except ready, which is ready = (state==IDLE) & ~reset.
- Reset values: all outputs 0, state INIT, sweep counter 0.
- Handshake:
  - Transfer occurs when req & ready are both high at a rising edge.
  - op, addr and accIn are latched at transfer; the requester may change them afterwards.
  - req while ready=0 is ignored, not queued.
- State INIT:
  - Each cycle drive bitRamEn=1, bitRamRw=0, bitRamIn=0, bitRamAddr=counter, then increment the counter.
  - After the write to address DEPTH-1, go to IDLE and set initDone=1.
  - Terminal detect is on DEPTH-1, not counter wrap.
  - The sweep takes exactly DEPTH cycles of strobes.
- State IDLE:
  - bitRamEn=0.
  - On transfer: legal op goes to ISSUE with strobes registered for the next cycle. Illegal op pulses opErr next cycle, stays in IDLE and makes no RAM access.
- State ISSUE (transfer at edge T, so ISSUE is cycle T+1):
  - LD/LDN: En=1, Rw=1, Addr=latched addr; next state RD_WAIT.
  - ST: En=1, Rw=0, In=accIn. STN: In=~accIn.
  - S: if accIn=1, write In=1; else En=0.
  - R: if accIn=1, write In=0; else En=0.
  - Write-class ops pulse wrDone in cycle T+2, go back to IDLE, and accept again at edge T+2.
  - S/R with accIn=0 still pulse wrDone, with no RAM write.
- State RD_WAIT (cycle T+2):
  - Hold En=1, Rw=1 and the same Addr, so bitRamOut stays driven and never goes Z.
  - At the end-of-cycle edge, capture rdData = bitRamOut XOR (op==LDN).
  - rdValid pulses in T+3 and the state returns to IDLE.
  - Read latency is 3 cycles from transfer; back-to-back reads run every 3 cycles, writes every 2.
- rdData holds its value until the next read capture.
- Reset mid-operation:
  - Any state goes to INIT. No rdValid/wrDone/opErr pulse for the aborted op.
  - The sweep restarts from 0 and initDone drops.
  - A write strobed in the same cycle as reset does not occur, because bitRam's reset branch has priority.
- bitRamEn is never 1 outside INIT, ISSUE and RD_WAIT.
- rdValid, wrDone and opErr are mutually exclusive in any cycle.

Decomposition:
- Shared package bit_ram_pkg holds: op encodings OP_LD..OP_R, state encoding (INIT, IDLE, ISSUE, RD_WAIT), and default ADDR_LEN/DEPTH matching defines.
- Optional sub-module bit_ram_init_sweep: counter plus terminal detect, outputs sweepAddr and sweepDone. Otherwise the block is flat.

Test Plan:
- Reset with DEPTH=16 -> ready=0 for 16 cycles; writes of 0 appear to addresses 0..15 in order; initDone=1 and ready=1 in cycle 17; no further strobes.
- After init, ST addr=5 accIn=1, then LD addr=5 -> wrDone at T+2; rdData=1 with rdValid at T+3 of the LD; LDN addr=5 -> rdData=0.
- S addr=7 accIn=0 -> wrDone pulses, bitRamEn stays 0; then S accIn=1 and LD addr=7 -> 1; then R accIn=1 and LD addr=7 -> 0.
- op=6 accepted -> opErr pulse next cycle; no bitRamEn; ready stays 1.
- Hold req=1 with LD addr=3 continuously -> transfers every 3 cycles; bitRamEn high only in ISSUE/RD_WAIT; bitRamOut never Z at the capture edge.
- Assert reset in the ISSUE cycle of ST addr=9 accIn=1 -> no wrDone; sweep restarts at addr 0; after init, LD addr=9 -> 0.
